bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Four-master round-robin bus arbiter. It sits in front of the shared bus, next to the master multiplexer and the address decoder. It grants the bus to one master at a time and rotates fairly between requesters. It also exports the current owner index that drives the master multiplexer select. An optional hold-limit watchdog preempts a master that keeps the bus while other masters are waiting.

## Interface
Parameters:
- HOLD_MAX, 16: maximum consecutive contended cycles an owner may hold the bus. Legal range 1..255. Used only with `BUS_ARB_HOLD_LIMIT_EN`.

Ports:
- clk  in  1  bus clock; all state updates on the rising edge.
- reset_  in  1  reset, asynchronous, active-low.
- m0_req_, m1_req_, m2_req_, m3_req_  in  1 each  bus request from masters 0..3, active-low.
- m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_  out  1 each  bus grant to masters 0..3, active-low. Exactly one is low at all times.
- owner  out  2  index of the current owner; select for the master multiplexer.
- arb_preempt  out  1  active-high, one-cycle pulse when a hold-limit preemption takes effect.

## Operation
- State:
  - `owner` register, 2 bits, encoding OWNER_0..OWNER_3.
  - `hold_cnt` register, 8 bits; present only with the macro.
- Grants are decoded combinationally from `owner`:
  - mN_grnt_ = `ENABLE_` (0) when owner == N; otherwise `DISABLE_` (1).
- Parking: the owner keeps its grant after it releases, as long as no other master requests.
- Release: the owner's request is deasserted (high) when sampled at an edge.
  - Rotation searches owner+1, owner+2, owner+3 (mod 4), in that order.
  - The first master found with req_ low becomes owner.
  - If none is found, owner is unchanged.
- Owner still requesting: no change, except for a hold-limit preemption.
- Requests from non-owners are never latched; only the level present at the edge counts.
- Contention means the owner's req_ is low AND at least one other req_ is low.
- Hold limit (macro only):
  - hold_cnt increments on every edge that samples contention.
  - hold_cnt clears to 0 on any owner change, and on any edge without contention.
  - When contention is sampled and hold_cnt == HOLD_MAX-1, the next edge rotates ownership as if the owner had released.
  - On that same edge, hold_cnt clears and arb_preempt is registered high for exactly one cycle.
  - The preempted master remains a requester and competes again in normal rotation.
- Release and hold-limit expiry in the same cycle: treated as a normal release; arb_preempt stays low.

## Timing
- Reset values:
  - owner = 0, so m0_grnt_ = 0 and m1..m3_grnt_ = 1.
  - hold_cnt = 0.
  - arb_preempt = 0.
- Reset assertion forces these values immediately, independent of clk. This holds even mid-transfer: the current owner loses its grant asynchronously.
- Latency:
  - A release or request sampled at edge k changes owner and the grants after edge k.
  - The new grant is valid throughout cycle k+1.
  - There is no combinational path from req_ to grnt_.
- Handover is at most one cycle after the owner releases. No cycle ever has zero or two grants.
- Worst-case wait for a requester:
  - Without the macro: unbounded, since the owner may hold indefinitely.
  - With the macro: at most 3×HOLD_MAX + 3 cycles while other masters are contending.
- hold_cnt saturates by construction, because expiry forces a clear. It never wraps.

## Configuration
- `BUS_ARB_HOLD_LIMIT_EN` defined:
  - hold_cnt and the preemption logic are built.
  - arb_preempt is functional.
- `BUS_ARB_HOLD_LIMIT_EN` undefined:
  - No counter is built.
  - Ownership changes only on release.
  - arb_preempt is tied to 0.
  - HOLD_MAX is ignored.

## Test plan
- Reset, no requests: owner=0, m0_grnt_=0, others=1. Hold for 10 cycles: no change, arb_preempt=0.
- Owner 0 holds; m2_req_ and m3_req_ go low; m0_req_ goes high at edge k: owner=2 in cycle k+1. When m2 releases: owner=3.
- Rotation fairness: all four req_ held low, each master releases for one cycle after its grant. Grant sequence 0→1→2→3→0 with no master skipped.
- Macro on, HOLD_MAX=4: m1 owns and never releases; m3_req_ goes low. After 4 contended edges: owner=3 and arb_preempt high for exactly 1 cycle. m1 regains the bus after m3 releases.
- Macro off, same stimulus: m1 keeps the grant for 100 cycles, arb_preempt=0.
- Reset asserted asynchronously mid-cycle while owner=2: grants switch to owner 0 without waiting for an edge. After reset_ rises, arbitration resumes from owner 0.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between four bus masters and the round-robin arbiter.
// Latency: wires only; grants are registered inside the arbiter.
// Backpressure: a master waits with its req_ low until its grnt_ goes low.
interface bus_arbiter_rr_if;
   logic       m0_req_;
   logic       m1_req_;
   logic       m2_req_;
   logic       m3_req_;
   logic       m0_grnt_;
   logic       m1_grnt_;
   logic       m2_grnt_;
   logic       m3_grnt_;
   logic [1:0] owner;
   logic       arb_preempt;

   // Requesting side: drives active-low requests, observes grants and owner.
   modport master (
      output m0_req_, m1_req_, m2_req_, m3_req_,
      input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, arb_preempt
   );

   // Arbiter side.
   modport slave (
      input  m0_req_, m1_req_, m2_req_, m3_req_,
      output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, arb_preempt
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with parking; optional hold-limit watchdog (BUS_ARB_HOLD_LIMIT_EN).
// Latency: request/release sampled at edge k changes owner and grants in cycle k+1; no req_->grnt_ path.
// Backpressure: waiting masters hold req_ low; the owner keeps the bus until it releases (or is preempted).
module bus_arbiter_rr #(
   parameter int HOLD_MAX = 16
) (
   input logic           clk,
   input logic           reset_,
   bus_arbiter_rr_if.slave bus
);

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {OWNER_0, OWNER_1, OWNER_2, OWNER_3} owner_e;

   // Watchdog range is 8-bit counter bound; reject nonsense at elaboration.
   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("bus_arbiter_rr: HOLD_MAX must be in 1..255");
   end

   owner_e     owner_q;
   owner_e     owner_d;
   logic [1:0] owner_idx;
   logic [3:0] req;
   logic       owner_req;
   logic       others_req;
   logic       contention;
   logic       found;
   logic [1:0] cand;
   logic       expire;

   assign req        = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
   assign owner_idx  = owner_q;
   assign owner_req  = req[owner_idx];
   assign others_req = |(req & ~(4'b0001 << owner_idx));
   assign contention = owner_req & others_req;

   // Nearest requester after the owner: scan offsets 3..1 so offset 1 wins last.
   always_comb begin
      found = 1'b0;
      cand  = owner_idx;
      for (int i = 3; i >= 1; i--) begin
         if (req[owner_idx + 2'(i)]) begin
            found = 1'b1;
            cand  = owner_idx + 2'(i);
         end
      end
   end

`ifdef BUS_ARB_HOLD_LIMIT_EN
   logic [7:0] hold_q;
   logic [7:0] hold_d;
   logic       preempt_q;

   assign expire = contention && (hold_q == 8'(HOLD_MAX - 1));
`else
   assign expire = 1'b0;
`endif

   // Next owner: rotate on release, or on watchdog expiry while others wait.
   always_comb begin
      owner_d = owner_q;
      if ((!owner_req || expire) && found) begin
         owner_d = owner_e'(cand);
      end
   end

   // Owner register; reset parks the bus on master 0 immediately.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         owner_q <= OWNER_0;
      end else begin
         owner_q <= owner_d;
      end
   end

`ifdef BUS_ARB_HOLD_LIMIT_EN
   // Contended-cycle count; any handover or quiet edge restarts it, so it never wraps.
   always_comb begin
      hold_d = 8'd0;
      if (owner_d == owner_q && contention) begin
         hold_d = hold_q + 8'd1;
      end
   end

   // Watchdog state and one-cycle preemption pulse.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= expire;
      end
   end

   assign bus.arb_preempt = preempt_q;
`else
   assign bus.arb_preempt = 1'b0;
`endif

   assign bus.owner    = owner_idx;
   assign bus.m0_grnt_ = (owner_q == OWNER_0) ? ENABLE_ : DISABLE_;
   assign bus.m1_grnt_ = (owner_q == OWNER_1) ? ENABLE_ : DISABLE_;
   assign bus.m2_grnt_ = (owner_q == OWNER_2) ? ENABLE_ : DISABLE_;
   assign bus.m3_grnt_ = (owner_q == OWNER_3) ? ENABLE_ : DISABLE_;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus random requests vs. a behavioural model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: n/a (bench drives requests freely).
module tb_bus_arbiter_rr;
   localparam int HOLD = 4;

   logic clk    = 1'b0;
   logic reset_ = 1'b1;

   always #5 clk = ~clk;

   bus_arbiter_rr_if bus ();

   bus_arbiter_rr #(.HOLD_MAX(HOLD)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive active-low request vector: bit n = mN_req_.
   task automatic set_req(input logic [3:0] r_);
      bus.m0_req_ = r_[0];
      bus.m1_req_ = r_[1];
      bus.m2_req_ = r_[2];
      bus.m3_req_ = r_[3];
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model ----------------
   int       m_owner = 0;
   int       m_held  = 0;   // contended edges the current owner has been granted through
   bit       m_pre   = 0;
   bit [3:0] want;
   bit       contend;
   bit       expire;
   bit       hit;
   int       nxt;

   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         m_owner = 0;
         m_held  = 0;
         m_pre   = 0;
      end else begin
         want    = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
         contend = want[m_owner] && ((want & ~(4'b0001 << m_owner)) != 4'b0000);
         expire  = 0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
         expire  = contend && (m_held + 1 == HOLD);
`endif
         nxt = m_owner;
         hit = 0;
         if (!want[m_owner] || expire) begin
            for (int i = 1; i < 4; i++) begin
               if (!hit && want[(m_owner + i) % 4]) begin
                  nxt = (m_owner + i) % 4;
                  hit = 1;
               end
            end
         end
         m_pre   = expire;
         m_held  = (nxt != m_owner || !contend) ? 0 : m_held + 1;
         m_owner = nxt;
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      chk("owner",   int'(bus.owner), m_owner);
      chk("m0_grnt_", int'(bus.m0_grnt_), (m_owner == 0) ? 0 : 1);
      chk("m1_grnt_", int'(bus.m1_grnt_), (m_owner == 1) ? 0 : 1);
      chk("m2_grnt_", int'(bus.m2_grnt_), (m_owner == 2) ? 0 : 1);
      chk("m3_grnt_", int'(bus.m3_grnt_), (m_owner == 3) ? 0 : 1);
      chk("preempt", int'(bus.arb_preempt), int'(m_pre));
      chk("one_grant", int'(bus.m0_grnt_) + int'(bus.m1_grnt_) + int'(bus.m2_grnt_) + int'(bus.m3_grnt_), 3);
   end

   // ---------------- stimulus ----------------
   logic [3:0] r_;

   initial begin
      set_req(4'b1111);
      #1 reset_ = 1'b0;
      #16 reset_ = 1'b1;

      // Reset state, idle for 10 cycles.
      chk("rst_owner", int'(bus.owner), 0);
      chk("rst_m0", int'(bus.m0_grnt_), 0);
      repeat (10) tick();
      chk("idle_owner", int'(bus.owner), 0);
      chk("idle_preempt", int'(bus.arb_preempt), 0);

      // Owner 0 holds, 2 and 3 wait, 0 releases -> 2, then 2 releases -> 3, then park.
      set_req(4'b1110); tick();
      set_req(4'b0010); tick();
      chk("hold0", int'(bus.owner), 0);
      set_req(4'b0011); tick();
      chk("rel0_to2", int'(bus.owner), 2);
      set_req(4'b0111); tick();
      chk("rel2_to3", int'(bus.owner), 3);
      set_req(4'b1111); tick(); tick();
      chk("park3", int'(bus.owner), 3);

      // Fairness: all requesting, owner releases one cycle after each grant.
      set_req(4'b0000); tick();
      for (int i = 0; i < 8; i++) begin
         r_ = 4'b0000;
         r_[bus.owner] = 1'b1;
         set_req(r_); tick();
         chk("rr_order", int'(bus.owner), (i + 4) % 4);
         set_req(4'b0000);
      end
      set_req(4'b1111); tick();

      // Hold-limit scenario: m1 owns and never releases, m3 waits.
      set_req(4'b1101); tick(); tick();
      chk("m1_owns", int'(bus.owner), 1);
      set_req(4'b0101);
`ifdef BUS_ARB_HOLD_LIMIT_EN
      repeat (HOLD - 1) tick();
      chk("pre_hold", int'(bus.owner), 1);
      chk("pre_nopulse", int'(bus.arb_preempt), 0);
      tick();
      chk("preempt_to3", int'(bus.owner), 3);
      chk("preempt_pulse", int'(bus.arb_preempt), 1);
      tick();
      chk("pulse_end", int'(bus.arb_preempt), 0);
      set_req(4'b1101); tick();
      chk("m1_regains", int'(bus.owner), 1);
`else
      repeat (100) tick();
      chk("no_wdog_owner", int'(bus.owner), 1);
      chk("no_wdog_preempt", int'(bus.arb_preempt), 0);
`endif

      // Asynchronous reset while owner = 2.
      set_req(4'b1011); tick(); tick();
      chk("own2", int'(bus.owner), 2);
      @(posedge clk);
      #3 reset_ = 1'b0;
      #1;
      chk("arst_owner", int'(bus.owner), 0);
      chk("arst_m2", int'(bus.m2_grnt_), 1);
      chk("arst_m0", int'(bus.m0_grnt_), 0);
      repeat (2) @(posedge clk);
      #2 reset_ = 1'b1;
      tick();
      chk("resume_from0", int'(bus.owner), 2);

      // Random traffic: each request flips with probability 1/4 per cycle.
      r_ = 4'b1111;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r_[b] = ~r_[b];
         end
         set_req(r_);
         tick();
      end

      set_req(4'b1111);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
